layer_serializer: RTL and testbench
===================================

# layer_serializer

Parallel-to-serial stage between two fully-connected layers. Captures the NN-wide output vector of a neuron layer in the cycle its neurons assert valid. Replays the values one per clock as a single dataWidth stream with a valid strobe, matching the serial `x_in`/`x_valid` input of the next layer's neurons. Sits directly downstream of each hidden layer.

## Interface
Parameters:
- `NN`, 30: number of neurons in the producing layer, i.e. elements per vector (≥2).
- `dataWidth`, 16: element width in bits, signed fixed-point, passed through unmodified.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `i_valid` input NN: per-neuron output valid. Only `i_valid[0]` is used; all neurons of a layer fire in the same cycle.
- `i_data` input NN*dataWidth: element k at `i_data[k*dataWidth +: dataWidth]`.
- `o_valid` output 1: registered, high while `o_data` carries an element.
- `o_data` output dataWidth: registered current element.
- `busy` output 1: combinational from state; high when an incoming vector cannot be accepted.
- `ovf` output 1: registered sticky overrun flag (see Configuration).

## Operation
- State: `IDLE`, `SHIFT`; element counter `cnt` (0..NN); vector buffer of NN*dataWidth bits.
- Capture condition: `i_valid[0]=1` and `busy=0`.
- `busy` = `SHIFT` and `cnt != NN`; it is 0 in `IDLE`.
- On capture:
  - `o_data <= i_data[dataWidth-1:0]`, `o_valid <= 1`.
  - Buffer is loaded with the remaining elements 1..NN-1.
  - `cnt <= 1`, state goes to `SHIFT`.
- In `SHIFT` with `cnt < NN`:
  - `o_data <=` next buffered element (elements in ascending index order).
  - `cnt <= cnt+1`, `o_valid` stays 1.
- In `SHIFT` with `cnt == NN` (last element on output):
  - If the capture condition holds, perform a capture. This gives a back-to-back stream with no gap.
  - Otherwise `o_valid <= 0`, `o_data` holds its last value, state goes to `IDLE`.
- Overrun is `i_valid[0]=1` while `busy=1`. The new vector is dropped. The in-progress vector completes uncorrupted.
- Elements are not altered: no saturation, no sign handling, bit-exact copy.
- `i_data` is sampled only in the capture cycle. Upstream may change it afterwards.

## Timing
- Reset values: `o_valid=0`, `o_data=0`, `ovf=0`, `busy=0`, state `IDLE`, `cnt=0`, buffer 0.
- `rst` asserted mid-burst clears all state immediately (asynchronous). The remaining elements are lost. The first capture after release starts at element 0.
- Latency: capture edge N → element 0 on `o_data` with `o_valid=1` in cycle N+1.
- Element k is presented in cycle N+1+k; `o_valid` stays high for exactly NN consecutive cycles, N+1..N+NN.
- `busy` is high in cycles N+1..N+NN-1 and low in cycle N+NN.
- A capture in cycle N+NN yields 2·NN contiguous valid cycles.
- Throughput: one vector per NN cycles maximum.
- No backpressure from downstream: the consumer must accept one element per cycle while `o_valid=1`.

## Configuration
- Macro `LAYER_SER_OVF_EN` (from `include.v`).
- Defined:
  - `ovf` is set on the edge where an overrun occurs.
  - It stays set until `rst`.
  - It is unaffected by later successful captures.
- Undefined:
  - No overrun detection logic.
  - `ovf` is tied to 0.
  - Overrun vectors are still dropped silently.
- Capture/shift behaviour is identical in both builds.

## Test plan
- Reset check: assert `rst` with no clock edges → `o_valid=0`, `o_data=0`, `busy=0`, `ovf=0`.
- Single vector: NN=30, element k = k+1, `i_valid` all-ones for 1 cycle at edge N → `o_valid` high cycles N+1..N+30 with `o_data` 1,2,…,30, then `o_valid=0` and `o_data` holds 30.
- Back-to-back: second vector (values 101..130) presented in cycle N+30 → 60 contiguous valid cycles 1..30 then 101..130, with no gap and `ovf=0`.
- Overrun: second vector presented in cycle N+5:
  - first vector streams 1..30 intact and the second never appears;
  - `ovf=1` from N+6 with `LAYER_SER_OVF_EN` defined, `ovf=0` without it.
- Async reset mid-burst: assert `rst` between edges during element 10 → `o_valid` drops at once. After release, a new vector (200..229) streams from 200 with a latency of 1.
- Bit-exactness: element values 16'h8001, 16'hFFFF, 16'h7FFF, 16'h0000 → reproduced unchanged on `o_data`.

Source files
------------

// File: rtl/layer_serializer.sv
// Parallel-to-serial stage: captures an NN-element layer output vector and replays it one element per clock.
// Optional sticky overrun flag enabled by defining LAYER_SER_OVF_EN.
module layer_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NN-1:0]             i_valid,
  input  logic [NN*dataWidth-1:0]   i_data,
  output logic                      o_valid,
  output logic [dataWidth-1:0]      o_data,
  output logic                      busy,
  output logic                      ovf
);

  localparam int CW = $clog2(NN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [NN*dataWidth-1:0] vbuf, vbuf_nxt;
  logic [dataWidth-1:0]    o_data_nxt;
  logic                    o_valid_nxt;
  logic                    capture;
  logic                    unused_valid;

  // All neurons of a layer fire together, so only lane 0 carries information.
  assign unused_valid = ^i_valid[NN-1:1];

  assign busy    = (state == SHIFT) && (cnt != CNT_LAST);
  assign capture = i_valid[0] && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      vbuf    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vbuf    <= vbuf_nxt;
      o_data  <= o_data_nxt;
      o_valid <= o_valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    vbuf_nxt    = vbuf;
    o_data_nxt  = o_data;
    o_valid_nxt = o_valid;
    if (capture) begin
      // Element 0 goes straight to the output; the buffer keeps 1..NN-1 right-aligned.
      o_data_nxt  = i_data[dataWidth-1:0];
      o_valid_nxt = 1'b1;
      vbuf_nxt    = {{dataWidth{1'b0}}, i_data[NN*dataWidth-1:dataWidth]};
      cnt_nxt     = CW'(1);
      state_nxt   = SHIFT;
    end else if (state == SHIFT) begin
      if (cnt != CNT_LAST) begin
        o_data_nxt  = vbuf[dataWidth-1:0];
        vbuf_nxt    = {{dataWidth{1'b0}}, vbuf[NN*dataWidth-1:dataWidth]};
        cnt_nxt     = cnt + CW'(1);
        o_valid_nxt = 1'b1;
      end else begin
        o_valid_nxt = 1'b0;
        cnt_nxt     = '0;
        state_nxt   = IDLE;
      end
    end
  end

`ifdef LAYER_SER_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (i_valid[0] && busy) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_layer_serializer;

  localparam int NN = 30;
  localparam int DW = 16;

`ifdef LAYER_SER_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NN-1:0]        i_valid = '0;
  logic [NN*DW-1:0]     i_data = '0;
  logic                 o_valid;
  logic [DW-1:0]        o_data;
  logic                 busy;
  logic                 ovf;

  int vectors = 0;
  int miscompares = 0;

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_data  (o_data),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: elements still to be presented wait in a queue.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else if (i_valid[0] && q.size() == 0) begin
      m_data  = i_data[DW-1:0];
      m_valid = 1'b1;
      for (int k = 1; k < NN; k++) q.push_back(i_data[k*DW +: DW]);
    end else if (q.size() != 0) begin
      if (i_valid[0] && OVF_EN) m_ovf = 1'b1;
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_o_valid", {31'b0, o_valid}, {31'b0, m_valid});
    chk("model_o_data",  {16'b0, o_data},  {16'b0, m_data});
    chk("model_busy",    {31'b0, busy},    {31'b0, (q.size() != 0)});
    chk("model_ovf",     {31'b0, ovf},     {31'b0, m_ovf});
  end

  function automatic logic [NN*DW-1:0] seq(input int base);
    logic [NN*DW-1:0] v;
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  // Drive a vector for one cycle, then scramble i_data; returns in the cycle after the capture edge.
  task automatic send(input logic [NN*DW-1:0] v);
    i_data  = v;
    i_valid = '1;
    @(negedge clk);
    i_valid = '0;
    for (int k = 0; k < NN; k++) i_data[k*DW +: DW] = DW'($urandom);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [NN*DW-1:0] bx;

  initial begin
    #1;
    chk("reset_o_valid", {31'b0, o_valid}, 32'd0);
    chk("reset_o_data",  {16'b0, o_data},  32'd0);
    chk("reset_busy",    {31'b0, busy},    32'd0);
    chk("reset_ovf",     {31'b0, ovf},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(2);

    // Single vector 1..30
    send(seq(1));
    chk("single_first", {16'b0, o_data}, 32'd1);
    chk("single_busy_first", {31'b0, busy}, 32'd1);
    cycles(29);
    chk("single_last", {16'b0, o_data}, 32'd30);
    chk("single_last_valid", {31'b0, o_valid}, 32'd1);
    chk("single_last_busy", {31'b0, busy}, 32'd0);
    cycles(1);
    chk("single_done_valid", {31'b0, o_valid}, 32'd0);
    chk("single_hold", {16'b0, o_data}, 32'd30);
    cycles(3);

    // Back-to-back: second vector presented in the last-element cycle
    send(seq(1));
    cycles(29);
    send(seq(101));
    chk("b2b_second_first", {16'b0, o_data}, 32'd101);
    chk("b2b_valid", {31'b0, o_valid}, 32'd1);
    chk("b2b_ovf", {31'b0, ovf}, 32'd0);
    cycles(29);
    chk("b2b_second_last", {16'b0, o_data}, 32'd130);
    cycles(3);

    // Overrun: second vector presented in cycle N+5
    send(seq(1));
    cycles(4);
    send(seq(301));
    chk("ovr_elem6", {16'b0, o_data}, 32'd6);
    chk("ovr_ovf", {31'b0, ovf}, {31'b0, OVF_EN});
    cycles(24);
    chk("ovr_last", {16'b0, o_data}, 32'd30);
    cycles(1);
    chk("ovr_dropped", {31'b0, o_valid}, 32'd0);
    cycles(3);

    // Async reset during element 10
    send(seq(1));
    cycles(9);
    chk("rst_elem10", {16'b0, o_data}, 32'd10);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_async_data", {16'b0, o_data}, 32'd0);
    chk("rst_async_ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(1);
    send(seq(200));
    chk("post_rst_first", {16'b0, o_data}, 32'd200);
    cycles(30);

    // Bit-exactness
    for (int k = 0; k < NN; k++) begin
      case (k % 4)
        0: bx[k*DW +: DW] = 16'h8001;
        1: bx[k*DW +: DW] = 16'hFFFF;
        2: bx[k*DW +: DW] = 16'h7FFF;
        default: bx[k*DW +: DW] = 16'h0000;
      endcase
    end
    send(bx);
    chk("bits_8001", {16'b0, o_data}, 32'h8001);
    cycles(1);
    chk("bits_ffff", {16'b0, o_data}, 32'hFFFF);
    cycles(1);
    chk("bits_7fff", {16'b0, o_data}, 32'h7FFF);
    cycles(1);
    chk("bits_0000", {16'b0, o_data}, 32'h0000);
    cycles(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
